// File: rtl/aes_pkg.sv
// AES shared types, tables and round-transform helpers.
// Used by the pipelined encrypt path and the iterative decrypt path.
package aes_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } inv_state_e;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    localparam logic [7:0] INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // multiply by a 4-bit constant (9, b, d, e for the inverse mix)
    function automatic logic [7:0] gmul(input logic [7:0] b, input logic [3:0] m);
        logic [7:0] x2, x4, x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return ({8{m[0]}} & b) ^ ({8{m[1]}} & x2) ^ ({8{m[2]}} & x4) ^ ({8{m[3]}} & x8);
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
    endfunction

    function automatic logic [127:0] add_round_key(input logic [127:0] s, input logic [127:0] k);
        return s ^ k;
    endfunction

    function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) r[8*i +: 8] = INV_SBOX[s[8*i +: 8]];
        return r;
    endfunction

    // byte k of the block sits at row k%4, column k/4, MSB first
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int c = 0; c < 4; c++)
            for (int w = 0; w < 4; w++)
                r[127-8*(4*c+w) -: 8] = s[127-8*(4*((c-w+4)%4)+w) -: 8];
        return r;
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] r;
        logic [7:0]   a0, a1, a2, a3;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            r[127-32*c -: 32] = {
                gmul(a0, 4'he) ^ gmul(a1, 4'hb) ^ gmul(a2, 4'hd) ^ gmul(a3, 4'h9),
                gmul(a0, 4'h9) ^ gmul(a1, 4'he) ^ gmul(a2, 4'hb) ^ gmul(a3, 4'hd),
                gmul(a0, 4'hd) ^ gmul(a1, 4'h9) ^ gmul(a2, 4'he) ^ gmul(a3, 4'hb),
                gmul(a0, 4'hb) ^ gmul(a1, 4'hd) ^ gmul(a2, 4'h9) ^ gmul(a3, 4'he)};
        end
        return r;
    endfunction

endpackage

// File: rtl/aes_inv_cipher_iter_round.sv
// One inverse-cipher round, combinational.
// The final round (last=1) skips InvMixColumns.
module aes_inv_round
    import aes_pkg::*;
(
    input  logic [127:0] state,
    input  logic [127:0] rk,
    input  logic         last,
    output logic [127:0] result
);

    logic [127:0] sb_ark;

    assign sb_ark = add_round_key(inv_sub_bytes(inv_shift_rows(state)), rk);
    assign result = last ? sb_ark : inv_mix_columns(sb_ark);

endmodule

// File: rtl/aes_inv_cipher_iter.sv
// Iterative AES inverse cipher, one round per clock.
// Shares the encrypt-order expanded key array with the encrypt path.
module aes_inv_cipher_iter
    import aes_pkg::*;
#(
    parameter  int Nk = 4,
    localparam int Nr = Nk + 6,
    localparam int RW = $clog2(Nr + 1)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [4*(Nr+1)-1:0][31:0]    rkey,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [127:0]                 ct,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [127:0]                 pt
);

    inv_state_e   st_q, st_d;
    logic [RW-1:0] rnd_q, rnd_d;
    logic [127:0] data_q, data_d;
    logic [127:0] rk_cur;
    logic [127:0] rk_last;
    logic [127:0] round_out;

    assign rk_last = rkey[4*Nr +: 4];
    assign pt      = data_q;

    // round-key mux indexed by the round counter
    always_comb begin
        rk_cur = '0;
        for (int i = 0; i <= Nr; i++)
            if (rnd_q == RW'(i)) rk_cur = rkey[4*i +: 4];
    end

    aes_inv_round u_round (
        .state  (data_q),
        .rk     (rk_cur),
        .last   (rnd_q == '0),
        .result (round_out)
    );

    // next-state, counter, datapath and handshake outputs
    always_comb begin
        st_d      = st_q;
        rnd_d     = rnd_q;
        data_d    = data_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (st_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    data_d = add_round_key(ct, rk_last);
                    rnd_d  = RW'(Nr - 1);
                    st_d   = ST_RUN;
                end
            end
            ST_RUN: begin
                data_d = round_out;
                if (rnd_q == '0) st_d = ST_DONE;
                else rnd_d = rnd_q - RW'(1);
            end
            ST_DONE: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
                if (out_ready) begin
                    if (in_valid) begin
                        data_d = add_round_key(ct, rk_last);
                        rnd_d  = RW'(Nr - 1);
                        st_d   = ST_RUN;
                    end else begin
                        st_d = ST_IDLE;
                    end
                end
            end
            default: st_d = ST_IDLE;
        endcase
    end

    // state, counter and block registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q   <= ST_IDLE;
            rnd_q  <= '0;
            data_q <= '0;
        end else begin
            st_q   <= st_d;
            rnd_q  <= rnd_d;
            data_q <= data_d;
        end
    end

endmodule

// File: doc/aes_inv_cipher_iter.md
Name: aes_inv_cipher_iter

Overview:
Iterative AES inverse cipher (FIPS-197 InvCipher) for AES-128/192/256. It performs one round per clock on a single shared datapath. The block accepts a ciphertext block on a valid/ready handshake and returns the plaintext on a valid/ready handshake. It uses the same expanded round-key word array as the pipelined encrypt path, so one key schedule serves both directions.

Parameters:
Nk, 4, key length in 32-bit words (4, 6 or 8 only)
Nr, Nk+6, number of rounds (derived; never overridden)

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
rkey  input  32 x 4*(Nr+1)  expanded key words in encryption order; round i key = {rkey[4i+3], rkey[4i+2], rkey[4i+1], rkey[4i]}
in_valid  input  1  ct is valid
in_ready  output  1  block can accept ct
ct  input  128  ciphertext block
out_valid  output  1  pt is valid
out_ready  input  1  consumer accepts pt
pt  output  128  plaintext block

Behaviour:
- Reset (async assert, sync release): FSM=IDLE, round counter=0, state register=0; in_ready=1, out_valid=0, pt=0.
- FSM states: IDLE, RUN, DONE.
- IDLE: in_ready=1. On in_valid&in_ready at edge T: state <= ct ^ rk[Nr]; rnd <= Nr-1; go to RUN.
- RUN: in_ready=0, out_valid=0. Each edge:
  - rnd>=1: state <= InvMixColumns(InvSubBytes(InvShiftRows(state)) ^ rk[rnd]); rnd <= rnd-1.
  - rnd==0: state <= InvSubBytes(InvShiftRows(state)) ^ rk[0]; go to DONE.
- Latency: out_valid rises after edge T+Nr (10/12/14 cycles after acceptance). rnd width = $clog2(Nr+1).
- DONE: out_valid=1, pt=state. pt and out_valid hold stable until out_valid&out_ready.
- in_ready = (FSM==IDLE) | (FSM==DONE & out_ready). Output and input handshakes in the same edge: pt is consumed and the new ct is loaded (state <= ct ^ rk[Nr], RUN), giving back-to-back throughput of one block per Nr+1 cycles.
- DONE with out_ready=1 and no in_valid: go to IDLE, out_valid=0. pt keeps the last value (don't-care once out_valid=0).
- in_valid while in RUN is ignored (in_ready=0); ct is not sampled.
- rkey is not registered: the source holds rkey stable from the acceptance edge until the output handshake. A change to rkey mid-operation gives undefined pt but must not corrupt the FSM.
- rst_n asserted in any state (including mid-RUN): immediate return to reset values; the in-flight block is discarded and no out_valid pulse occurs.
- Round-key selection is a mux on rnd over the Nr+1 packed keys. No key-schedule logic lives in this block.

Decomposition:
- aes_pkg (shared) gains: inverse S-box constant table, InvSubBytes, InvShiftRows and InvMixColumns functions (GF(2^8) xtime-based multiplies by 9/b/d/e), alongside the existing forward functions and AddRoundKey.
- aes_pkg also gains a state enum type for IDLE/RUN/DONE.
- One natural sub-module: aes_inv_round. It is combinational, with inputs state, rk and a last flag, and computes either the middle-round or the final-round transform. The top is then FSM, counter, key mux and registers.

Test Plan:
1. Nk=4, FIPS-197 App. C.1 key 000102…0f, ct 69c4e0d86a7b0430d8cdb78070b4c55a -> out_valid exactly 10 cycles after acceptance, pt 00112233445566778899aabbccddeeff.
2. Nk=6 key 000102…17, ct dda97ca4864cdfe06eaf70a0ec0d7191 -> after 12 cycles, pt 00112233445566778899aabbccddeeff. Nk=8 key 000102…1f, ct 8ea2b7ca516745bfeafc49904b496089 -> after 14 cycles, same pt.
3. Backpressure: hold out_ready=0 for 20 cycles after out_valid -> pt stable, in_ready=0, in_valid pulses ignored. Release -> single output handshake.
4. Back-to-back: in_valid held high with two C.1 ciphertexts and out_ready=1 -> second ct accepted on the same edge as the first pt handshake; outputs spaced 11 cycles apart, both correct.
5. Reset mid-RUN (rst_n low at round 5, async to clk) -> out_valid=0, pt=0, in_ready=1 immediately. No stale output after release. A following block decrypts correctly.
6. Round-trip: 1000 random key/pt pairs through the existing pipelined encrypt path into this block, random in_valid/out_ready -> every pt matches, no drops or duplicates.
